// File: rtl/wb_reg_bank_pkg.sv
// Shared constants and helpers for the Wishbone register bank.
//   WB_ADR_LSB  : lowest word-address bit on the bus (byte address bits 1:0 dropped)
//   clog2()     : ceiling log2, usable in parameter expressions
//   sel_to_mask : expands a byte-lane select into a bit mask (MAX_DATA_W wide,
//                 callers truncate to their own data width)
package wb_reg_bank_pkg;

  localparam int WB_ADR_LSB = 2;
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_SEL_W  = MAX_DATA_W / 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] sel_to_mask(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_SEL_W; i++) begin
      mask[i*8 +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_reg_bank_wbif.sv
// Wishbone slave handshake for the register bank.
// Tracks read/write in progress, captures accepted writes into a one-deep
// pipeline register and generates ack/err/stall. Address decode is done by
// the parent and fed back through i_rd_mapped / i_wr_mapped.
//   wb_*          : Wishbone slave signals (request side, ack/err/stall)
//   i_rd_mapped   : current bus address hits a mapped word
//   i_wr_mapped   : pipelined write address hits a mapped word
//   o_rd_accept   : read accepted this cycle (parent registers read data)
//   o_wr_valid    : pipeline holds a write accepted last cycle
//   o_wr_adr/sel/dat : captured write request
module wb_reg_bank_wbif
  import wb_reg_bank_pkg::*;
#(
  parameter int ADR_W  = 1,
  parameter int DATA_W = 32,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                wb_cyc_i,
  input  logic                                wb_stb_i,
  input  logic                                wb_we_i,
  input  logic [ADR_W+WB_ADR_LSB-1:WB_ADR_LSB] wb_adr_i,
  input  logic [SEL_W-1:0]                    wb_sel_i,
  input  logic [DATA_W-1:0]                   wb_dat_i,
  input  logic                                i_rd_mapped,
  input  logic                                i_wr_mapped,
  output logic                                wb_ack_o,
  output logic                                wb_err_o,
  output logic                                wb_stall_o,
  output logic                                o_rd_accept,
  output logic                                o_wr_valid,
  output logic [ADR_W-1:0]                    o_wr_adr,
  output logic [SEL_W-1:0]                    o_wr_sel,
  output logic [DATA_W-1:0]                   o_wr_dat
);

  logic              r_rip;
  logic              r_wip;
  logic              r_rd_ack;
  logic              r_rd_err;
  logic              r_wr_req;
  logic [ADR_W-1:0]  r_wr_adr;
  logic [SEL_W-1:0]  r_wr_sel;
  logic [DATA_W-1:0] r_wr_dat;

  logic w_req;
  logic w_rd_accept;
  logic w_wr_accept;
  logic w_wr_ack;
  logic w_wr_err;

  // A kind of transfer is blocked only while its own predecessor is in
  // flight; reads and writes proceed independently.
  assign w_req       = wb_cyc_i & wb_stb_i;
  assign w_rd_accept = w_req & ~wb_we_i & ~r_rip;
  assign w_wr_accept = w_req &  wb_we_i & ~r_wip;

  // Write response comes straight from the pipeline register in T+1.
  assign w_wr_ack = r_wr_req &  i_wr_mapped;
  assign w_wr_err = r_wr_req & ~i_wr_mapped;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rip    <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_rd_ack <= w_rd_accept &  i_rd_mapped;
      r_rd_err <= w_rd_accept & ~i_rd_mapped;
      if (w_rd_accept) begin
        r_rip <= 1'b1;
      end else if (r_rd_ack || r_rd_err) begin
        r_rip <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wip    <= 1'b0;
      r_wr_req <= 1'b0;
      r_wr_adr <= '0;
      r_wr_sel <= '0;
      r_wr_dat <= '0;
    end else begin
      r_wr_req <= w_wr_accept;
      if (w_wr_accept) begin
        r_wip    <= 1'b1;
        r_wr_adr <= wb_adr_i;
        r_wr_sel <= wb_sel_i;
        r_wr_dat <= wb_dat_i;
      end else if (w_wr_ack || w_wr_err) begin
        r_wip <= 1'b0;
      end
    end
  end

  assign wb_ack_o    = r_rd_ack | w_wr_ack;
  assign wb_err_o    = r_rd_err | w_wr_err;
  assign wb_stall_o  = w_req & ~(wb_ack_o | wb_err_o);
  assign o_rd_accept = w_rd_accept;
  assign o_wr_valid  = r_wr_req;
  assign o_wr_adr    = r_wr_adr;
  assign o_wr_sel    = r_wr_sel;
  assign o_wr_dat    = r_wr_dat;

endmodule

// File: rtl/wb_reg_bank.sv
// Parametrised Wishbone register bank.
// Words 0..NREGS-1 are read/write control registers with byte-lane writes;
// words NREGS..NREGS+NRO-1 expose the ro_i status inputs; the rest of the
// 2^ADR_W window answers with wb_err_o.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   wb_*           : Wishbone slave port (classic or pipelined)
//   regs_o         : register contents, register k in slice k
//   wr_pulse_o     : one-cycle pulse per register written
//   ro_i           : status words, word k in slice k
module wb_reg_bank
  import wb_reg_bank_pkg::*;
#(
  parameter int NREGS  = 4,
  parameter int NRO    = 0,
  parameter int DATA_W = 32,
  parameter logic [NREGS*DATA_W-1:0] RESET_VAL = '0,
  localparam int ADR_W = (NREGS + NRO > 1) ? clog2(NREGS + NRO) : 1,
  localparam int SEL_W = DATA_W / 8,
  localparam int RO_W  = ((NRO > 0) ? NRO : 1) * DATA_W
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                wb_cyc_i,
  input  logic                                wb_stb_i,
  input  logic [ADR_W+WB_ADR_LSB-1:WB_ADR_LSB] wb_adr_i,
  input  logic [SEL_W-1:0]                    wb_sel_i,
  input  logic                                wb_we_i,
  input  logic [DATA_W-1:0]                   wb_dat_i,
  output logic                                wb_ack_o,
  output logic                                wb_err_o,
  output logic                                wb_rty_o,
  output logic                                wb_stall_o,
  output logic [DATA_W-1:0]                   wb_dat_o,
  output logic [NREGS*DATA_W-1:0]             regs_o,
  output logic [NREGS-1:0]                    wr_pulse_o,
  input  logic [RO_W-1:0]                     ro_i
);

  // One extra bit so NREGS+NRO == 2^ADR_W does not wrap to zero.
  localparam logic [ADR_W:0] NUM_RW  = (ADR_W+1)'(NREGS);
  localparam logic [ADR_W:0] NUM_MAP = (ADR_W+1)'(NREGS + NRO);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_dat;
  logic [NREGS-1:0]  r_wr_pulse;

  logic              w_rd_accept;
  logic              w_rd_mapped;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_wr_valid;
  logic              w_wr_mapped;
  logic              w_wr_load;
  logic [ADR_W-1:0]  w_wr_adr;
  logic [SEL_W-1:0]  w_wr_sel;
  logic [DATA_W-1:0] w_wr_dat;
  logic [DATA_W-1:0] w_wr_mask;
  logic [NREGS-1:0]  w_wr_hit;
  logic              w_unused_ro;

  wb_reg_bank_wbif #(
    .ADR_W  (ADR_W),
    .DATA_W (DATA_W)
  ) u_wbif (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_sel_i    (wb_sel_i),
    .wb_dat_i    (wb_dat_i),
    .i_rd_mapped (w_rd_mapped),
    .i_wr_mapped (w_wr_mapped),
    .wb_ack_o    (wb_ack_o),
    .wb_err_o    (wb_err_o),
    .wb_stall_o  (wb_stall_o),
    .o_rd_accept (w_rd_accept),
    .o_wr_valid  (w_wr_valid),
    .o_wr_adr    (w_wr_adr),
    .o_wr_sel    (w_wr_sel),
    .o_wr_dat    (w_wr_dat)
  );

  assign w_rd_mapped = {1'b0, wb_adr_i} < NUM_MAP;
  assign w_wr_mapped = {1'b0, w_wr_adr} < NUM_MAP;
  // Writes to status words are acknowledged but never load anything; an
  // all-zero sel is a legal no-op and must not pulse.
  assign w_wr_load   = w_wr_valid & ({1'b0, w_wr_adr} < NUM_RW) & (|w_wr_sel);
  assign w_wr_mask   = DATA_W'(sel_to_mask(MAX_SEL_W'(w_wr_sel)));

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (wb_adr_i == ADR_W'(k)) w_rd_data = r_regs[k];
    end
    for (int k = 0; k < NRO; k++) begin
      if (wb_adr_i == ADR_W'(NREGS + k)) w_rd_data = ro_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_wr_hit = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_wr_hit[k] = w_wr_load && (w_wr_adr == ADR_W'(k));
    end
  end

  // NOTE: the register array is reset on purpose: software expects
  // RESET_VAL the instant reset asserts. Large storage arrays normally stay
  // unreset so they can map onto RAM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= RESET_VAL[k*DATA_W +: DATA_W];
      end
      r_wr_pulse <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (w_wr_hit[k]) r_regs[k] <= (r_regs[k] & ~w_wr_mask) | (w_wr_dat & w_wr_mask);
      end
      r_wr_pulse <= w_wr_hit;
    end
  end

  // Read data only moves on a mapped read; errored reads leave it alone.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dat <= '0;
    end else if (w_rd_accept && w_rd_mapped) begin
      r_dat <= w_rd_data;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NREGS; k++) begin
      regs_o[k*DATA_W +: DATA_W] = r_regs[k];
    end
  end

  assign wb_dat_o    = r_dat;
  assign wr_pulse_o  = r_wr_pulse;
  assign wb_rty_o    = 1'b0;
  // ro_i is a dummy word when NRO = 0.
  assign w_unused_ro = ^ro_i;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Self-checking bench for wb_reg_bank (NREGS=4, NRO=2, DATA_W=32).
// A transaction-level model tracks accepted requests and predicts every
// output each cycle; directed literal checks pin the model to known values.
module tb_wb_reg_bank;

  localparam int NREGS  = 4;
  localparam int NRO    = 2;
  localparam int DATA_W = 32;
  localparam int ADR_W  = 3;
  localparam logic [NREGS*DATA_W-1:0] RESET_VAL = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};

  logic                    clk   = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cyc   = 1'b0;
  logic                    stb   = 1'b0;
  logic                    we    = 1'b0;
  logic [ADR_W+1:2]        adr   = '0;
  logic [3:0]              sel   = '0;
  logic [31:0]             dat_i = '0;
  logic [NRO*DATA_W-1:0]   ro    = '0;
  logic                    ack, err, rty, stall;
  logic [31:0]             dat_o;
  logic [NREGS*DATA_W-1:0] regs;
  logic [NREGS-1:0]        pulse;

  int n_checks = 0;
  int n_errors = 0;

  wb_reg_bank #(
    .NREGS     (NREGS),
    .NRO       (NRO),
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_adr_i   (adr),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_dat_i   (dat_i),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .wb_rty_o   (rty),
    .wb_stall_o (stall),
    .wb_dat_o   (dat_o),
    .regs_o     (regs),
    .wr_pulse_o (pulse),
    .ro_i       (ro)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    int          adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  logic [31:0] m_regs [NREGS];
  logic [31:0] m_dat;
  txn_t        rd1, wr1, wr2;   // read accepted last cycle; writes 1 and 2 cycles ago

  function automatic bit is_mapped(input int a);
    return a < NREGS + NRO;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a < NREGS) return m_regs[a];
    if (a < NREGS + NRO) return ro[(a - NREGS)*32 +: 32];
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e_pulse;
    logic       e_ack, e_err, e_stall;
    txn_t       nrd, nwr;
    e_pulse = '0;
    e_ack   = 1'b0;
    e_err   = 1'b0;
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) m_regs[k] = RESET_VAL[k*32 +: 32];
      m_dat = '0;
      rd1   = '{default: 0};
      wr1   = '{default: 0};
      wr2   = '{default: 0};
    end else begin
      // A write lands two cycles after acceptance.
      if (wr2.v && wr2.adr < NREGS && wr2.sel != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (wr2.sel[b]) m_regs[wr2.adr][b*8 +: 8] = wr2.dat[b*8 +: 8];
        end
        e_pulse[wr2.adr] = 1'b1;
      end
      e_ack = (rd1.v && is_mapped(rd1.adr)) || (wr1.v && is_mapped(wr1.adr));
      e_err = (rd1.v && !is_mapped(rd1.adr)) || (wr1.v && !is_mapped(wr1.adr));
      if (rd1.v && is_mapped(rd1.adr)) m_dat = rd1.dat;
    end
    e_stall = cyc && stb && !(e_ack || e_err);

    check("ack",   64'(ack),   64'(e_ack));
    check("err",   64'(err),   64'(e_err));
    check("rty",   64'(rty),   64'h0);
    check("stall", 64'(stall), 64'(e_stall));
    check("dat_o", 64'(dat_o), 64'(m_dat));
    check("pulse", 64'(pulse), 64'(e_pulse));
    for (int k = 0; k < NREGS; k++) begin
      check($sformatf("regs[%0d]", k), 64'(regs[k*32 +: 32]), 64'(m_regs[k]));
    end

    if (rst_n) begin
      nrd = '{default: 0};
      nwr = '{default: 0};
      // Same-kind request is refused only while its predecessor awaits ack.
      if (cyc && stb && !we && !rd1.v) begin
        nrd.v   = 1'b1;
        nrd.adr = int'(adr);
        nrd.dat = model_read(nrd.adr);
      end
      if (cyc && stb && we && !wr1.v) begin
        nwr.v   = 1'b1;
        nwr.adr = int'(adr);
        nwr.dat = dat_i;
        nwr.sel = sel;
      end
      wr2 = wr1;
      wr1 = nwr;
      rd1 = nrd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One-cycle request; returns 1 time unit into the following cycle.
  task automatic wb_req(input logic w, input int a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk);
    #1;
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = w;
    adr   = 3'(a);
    dat_i = d;
    sel   = s;
    @(posedge clk);
    #1;
    cyc = 1'b0;
    stb = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset regs[1]", 64'(regs[63:32]), 64'hDEADBEEF);
    check("reset ack",     64'(ack),         64'h0);
    check("reset pulse",   64'(pulse),       64'h0);
    check("reset dat_o",   64'(dat_o),       64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Full-word write to word 2.
    wb_req(1'b1, 2, 32'h12345678, 4'hF);
    @(negedge clk);
    check("w2 ack T+1",   64'(ack),   64'h1);
    check("w2 pulse T+1", 64'(pulse), 64'h0);
    @(posedge clk);
    @(negedge clk);
    check("w2 regs T+2",  64'(regs[95:64]), 64'h12345678);
    check("w2 pulse T+2", 64'(pulse),       64'h4);
    @(posedge clk);
    @(negedge clk);
    check("w2 pulse T+3", 64'(pulse), 64'h0);

    // Byte-lane merge on word 0.
    idle(1);
    wb_req(1'b1, 0, 32'hFFFFFFFF, 4'hF);
    idle(1);
    wb_req(1'b1, 0, 32'h00000000, 4'h5);
    idle(1);
    wb_req(1'b0, 0, 32'h0, 4'h0);
    @(negedge clk);
    check("rd0 merged", 64'(dat_o), 64'hFF00FF00);

    // Status words.
    ro = {32'h5A5A0002, 32'hCAFE0001};
    idle(1);
    wb_req(1'b0, 4, 32'h0, 4'h0);
    @(negedge clk);
    check("ro rd", 64'(dat_o), 64'hCAFE0001);
    idle(1);
    wb_req(1'b1, 4, 32'h11111111, 4'hF);
    @(negedge clk);
    check("ro wr ack", 64'(ack), 64'h1);
    @(posedge clk);
    @(negedge clk);
    check("ro wr pulse", 64'(pulse), 64'h0);
    idle(1);
    wb_req(1'b0, 4, 32'h0, 4'h0);
    @(negedge clk);
    check("ro rd after wr", 64'(dat_o), 64'hCAFE0001);

    // Unmapped word 6.
    idle(1);
    wb_req(1'b0, 6, 32'h0, 4'h0);
    @(negedge clk);
    check("unmapped rd err", 64'(err),   64'h1);
    check("unmapped rd ack", 64'(ack),   64'h0);
    check("unmapped rd dat", 64'(dat_o), 64'hCAFE0001);
    idle(1);
    wb_req(1'b1, 6, 32'h99999999, 4'hF);
    @(negedge clk);
    check("unmapped wr err", 64'(err), 64'h1);
    check("unmapped wr ack", 64'(ack), 64'h0);
    @(posedge clk);
    @(negedge clk);
    check("unmapped wr err T+2", 64'(err),         64'h0);
    check("unmapped wr pulse",   64'(pulse),       64'h0);
    check("unmapped wr regs0",   64'(regs[31:0]),  64'hFF00FF00);

    // Reset during a write's ack cycle.
    idle(1);
    wb_req(1'b1, 1, 32'hAAAA5555, 4'hF);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst mid ack",     64'(ack),          64'h0);
    check("rst mid regs[1]", 64'(regs[63:32]),  64'hDEADBEEF);
    check("rst mid regs[2]", 64'(regs[95:64]),  64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst mid pulse",   64'(pulse),        64'h0);
    check("rst mid regs[1] after", 64'(regs[63:32]), 64'hDEADBEEF);

    // Randomised traffic checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      cyc   = ($urandom_range(0, 9) != 0);
      stb   = cyc && ($urandom_range(0, 2) != 0);
      we    = 1'($urandom_range(0, 1));
      adr   = 3'($urandom_range(0, 7));
      sel   = 4'($urandom_range(0, 15));
      dat_i = $urandom;
      if ($urandom_range(0, 7) == 0) ro = {$urandom, $urandom};
      if (i == 300) rst_n = 1'b0;
      if (i == 302) rst_n = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc = 1'b0;
    stb = 1'b0;
    idle(4);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_bank.md
# wb_reg_bank

Parametrised Wishbone register bank: NREGS read/write control registers plus NRO read-only status inputs behind one classic/pipelined Wishbone slave. Generalises the fixed one-register-per-port blocks with configurable width and count, byte-lane writes, per-register write pulses and bus errors on unmapped addresses. Sits directly on a Wishbone crossbar port, next to the logic it controls.

## Interface
- NREGS, 4: number of R/W registers, 1..64
- NRO, 0: number of read-only status words, 0..64
- DATA_W, 32: register and bus data width, multiple of 8
- RESET_VAL, '0: packed NREGS*DATA_W reset values, register k in slice k
- ADR_W, derived: clog2(NREGS+NRO), minimum 1

- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous assert, active-low
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_adr_i  in  [ADR_W+1:2]  word address
- wb_sel_i  in  DATA_W/8  byte lane select
- wb_we_i  in  1  write enable
- wb_dat_i  in  DATA_W  write data
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  error acknowledge, unmapped address
- wb_rty_o  out  1  tied 0
- wb_stall_o  out  1  pipelined stall
- wb_dat_o  out  DATA_W  read data, registered
- regs_o  out  NREGS*DATA_W  register contents, register k in slice k
- wr_pulse_o  out  NREGS  one-cycle pulse per register write
- ro_i  in  NRO*DATA_W  status words, width 1 when NRO=0

## Operation
- Map: word 0..NREGS-1 = R/W registers; NREGS..NREGS+NRO-1 = ro_i words; remaining words in 2^ADR_W window unmapped.
- Request accepted when cyc&stb high and no read (rip) or write (wip) of the same kind in progress; rip/wip clear on the respective ack/err.
- Write to R/W word: only byte lanes with wb_sel_i set updated; other lanes hold. wr_pulse_o[k] asserts iff at least one sel bit set.
- Write to ro_i word: acked, discarded, no pulse.
- Read: returns register or ro_i word; sel ignored.
- Unmapped read or write: wb_err_o instead of wb_ack_o, same latency; no state change, wb_dat_o held at previous value.
- wb_stall_o = cyc&stb & ~(ack|err).
- Reset (async): regs_o = RESET_VAL; wb_ack_o, wb_err_o, wr_pulse_o, rip, wip, write pipeline = 0; wb_dat_o = 0; wb_rty_o = 0 always.

## Timing
- Request accepted in cycle T.
- Read: address decoded and data muxed combinationally in T, registered; wb_ack_o/wb_err_o and wb_dat_o valid in T+1 (one-cycle latency). ro_i sampled at end of T.
- Write: adr/dat/sel/req registered at end of T; ack/err combinational from pipeline in T+1; register loads at end of T+1; regs_o new value and wr_pulse_o[k] high in T+2, pulse exactly one cycle.
- Back-to-back writes: next write accepted T+2, pulses one per write, never merged.
- Read accepted while write pending in pipeline: independent paths, both acks may coincide; read in T+1 of write to same register returns old value.
- cyc dropped after acceptance: ack/err still issued in T+1; write still takes effect.
- Reset asserted mid-transfer: transfer aborted, no ack, registers forced to RESET_VAL immediately.

## Structure
- Package wb_reg_bank_pkg: WB_ADR_LSB = 2 constant, clog2 helper function, function expanding sel to a DATA_W byte mask.
- Sub-module wb_reg_bank_wbif: rip/wip tracking, ack/err/stall generation, write pipeline register; top holds decode, register array and read mux.

## Test plan
- Reset with RESET_VAL slice 1 = 0xDEADBEEF, NREGS=4 -> regs_o slice 1 = 0xDEADBEEF, all acks/pulses 0, wb_dat_o = 0.
- Write 0x12345678 sel=0xF to word 2 -> ack at T+1, regs_o slice 2 = 0x12345678 and wr_pulse_o = 0b0100 in T+2 only.
- Word 0 = 0xFFFFFFFF, write 0x00000000 sel=0x5 -> read word 0 returns 0xFF00FF00.
- NRO=2, ro_i word 0 = 0xCAFE0001 -> read word 4 returns 0xCAFE0001 at T+1; write to word 4 acked, no pulse, value unchanged.
- NREGS=4, NRO=2, read and write word 6 -> wb_err_o one cycle at T+1, wb_ack_o 0, no register change, wb_dat_o unchanged.
- Write accepted, rst_n_i low in T+1 -> no ack, regs_o = RESET_VAL, no pulse.
